// File: rtl/fmap_pingpong_ctrl_if.sv
// Handshake and bus bundle between the ping-pong controller, the pixel source,
// BRAM port A and the 5x5 window generator.
interface fmap_pingpong_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              bram_ena;
  logic              bram_wea;
  logic [ADDR_W:0]   bram_addra;
  logic [DATA_W-1:0] bram_dina;
  logic              rd_bank;
  logic              win_en;
  logic              win_done;

  modport master (
    input  s_valid, s_data, win_done,
    output s_ready, bram_ena, bram_wea, bram_addra, bram_dina, rd_bank, win_en
  );

  modport slave (
    output s_valid, s_data, win_done,
    input  s_ready, bram_ena, bram_wea, bram_addra, bram_dina, rd_bank, win_en
  );
endinterface

// File: rtl/fmap_pingpong_ctrl.sv
// Ping-pong frame-buffer controller: writes incoming frames into alternating
// BRAM banks while the window generator consumes the other bank.
module fmap_pingpong_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg_hs_num,
  input  logic [7:0]            cfg_vs_num,
  fmap_pingpong_ctrl_if.master  bus,
  output logic [15:0]           frame_cnt,
  output logic                  cfg_err
);

  localparam int unsigned SZ_W  = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_GAP} rd_state_e;

  rd_state_e         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SZ_W-1:0]   frame_size_q, frame_size_d;
  logic              cfg_err_q, cfg_err_d;
  logic              ena_q, ena_d;
  logic [ADDR_W:0]   addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              rd_bank_q, rd_bank_d;
  logic              win_en_q, win_en_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              s_ready_c;
  logic              accept_c;
  logic [15:0]       prod_c;
  logic              size_bad_c;
  logic [SZ_W-1:0]   size_new_c;
  logic [SZ_W-1:0]   size_cur_c;
  logic              last_c;

  // Frame size is taken from cfg on the first pixel, so that pixel must see it too.
  always_comb begin
    s_ready_c  = !full_q[wr_bank_q];
    accept_c   = bus.s_valid && s_ready_c;
    prod_c     = 16'(cfg_hs_num) * 16'(cfg_vs_num);
    size_bad_c = (prod_c == 16'd0) || (32'(prod_c) > DEPTH);
    size_new_c = size_bad_c ? SZ_W'(DEPTH) : SZ_W'(prod_c);
    size_cur_c = (wr_addr_q == '0) ? size_new_c : frame_size_q;
    last_c     = ({1'b0, wr_addr_q} == (size_cur_c - SZ_W'(1)));
  end

  // Writer and reader next-state; set and clear of full touch different banks.
  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    frame_size_d = frame_size_q;
    cfg_err_d    = cfg_err_q;
    ena_d        = accept_c;
    addra_d      = addra_q;
    dina_d       = dina_q;
    rd_bank_d    = rd_bank_q;
    frame_cnt_d  = frame_cnt_q;

    if (accept_c) begin
      addra_d   = {wr_bank_q, wr_addr_q};
      dina_d    = bus.s_data;
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      if (wr_addr_q == '0) begin
        frame_size_d = size_new_c;
        if (size_bad_c) cfg_err_d = 1'b1;
      end
      if (last_c) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_addr_d         = '0;
      end
    end

    case (state_q)
      RD_IDLE: if (full_q[rd_bank_q]) state_d = RD_RUN;
      RD_RUN: begin
        if (bus.win_done) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          frame_cnt_d       = frame_cnt_q + 16'd1;
          state_d           = RD_GAP;
        end
      end
      RD_GAP:  state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase

    win_en_d = (state_d == RD_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RD_IDLE;
      full_q       <= 2'b00;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      frame_size_q <= '0;
      cfg_err_q    <= 1'b0;
      ena_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      rd_bank_q    <= 1'b0;
      win_en_q     <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      frame_size_q <= frame_size_d;
      cfg_err_q    <= cfg_err_d;
      ena_q        <= ena_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      rd_bank_q    <= rd_bank_d;
      win_en_q     <= win_en_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.bram_ena   = ena_q;
  assign bus.bram_wea   = ena_q;
  assign bus.bram_addra = addra_q;
  assign bus.bram_dina  = dina_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.win_en     = win_en_q;
  assign frame_cnt      = frame_cnt_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: doc/fmap_pingpong_ctrl.md
# fmap_pingpong_ctrl

Ping-pong frame-buffer controller between the incoming pixel stream and the 5x5 window generator. It writes each feature-map frame into one half of the dual-port BRAM (port A) while the window generator reads the previously completed frame from the other half (port B). It owns bank selection, write addressing, the window generator's run-enable, and per-frame completion tracking. The result is that streaming input and window extraction overlap without corrupting each other.

## Interface
- ADDR_W, 10: per-bank address width; bank depth = 2**ADDR_W pixels.
- DATA_W, 8: pixel width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_hs_num  in  8  frame width in pixels; sampled at first accepted pixel of each frame.
- cfg_vs_num  in  8  frame height in rows; sampled with cfg_hs_num.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  controller can accept a pixel this cycle.
- s_data  in  DATA_W  input pixel.
- bram_ena  out  1  port A enable.
- bram_wea  out  1  port A write enable.
- bram_addra  out  ADDR_W+1  port A address; MSB = bank.
- bram_dina  out  DATA_W  port A write data.
- rd_bank  out  1  bank the window generator reads; externally concatenated as MSB of port B address.
- win_en  out  1  window generator run-enable (drives its data-enable input); level.
- win_done  in  1  single-cycle pulse from window generator: frame fully consumed.
- frame_cnt  out  16  frames consumed since reset; wraps.
- cfg_err  out  1  sticky; illegal frame size seen.

## Operation
- State per bank: full[1:0]. Write pointer wr_bank, read pointer rd_bank, write offset wr_addr[ADDR_W-1:0].
- s_ready = !full[wr_bank] (combinational).
- Accept = s_valid && s_ready. On an accept at wr_addr==0, latch frame_size = cfg_hs_num*cfg_vs_num (16-bit product).
- If the product is 0 or exceeds 2**ADDR_W, use frame_size = 2**ADDR_W and set cfg_err. cfg_err clears only on reset.
- Each accept registers bram_ena=bram_wea=1, bram_addra={wr_bank,wr_addr}, bram_dina=s_data, then increments wr_addr.
- Accept with wr_addr==frame_size-1:
  - set full[wr_bank]
  - toggle wr_bank
  - clear wr_addr.
- Read FSM (rd_bank starts 0):
  - IDLE: win_en=0. If full[rd_bank], go to RUN.
  - RUN: win_en=1. On win_done: clear full[rd_bank], toggle rd_bank, increment frame_cnt, go to GAP.
  - GAP: win_en=0 for exactly one cycle, which re-arms the window generator. Then go to IDLE.
  - win_done outside RUN is ignored.
- Writer and reader never target the same bank concurrently. A set of full[wr_bank] and a clear of full[rd_bank] in the same cycle touch different bits; both must take effect.
- rd_bank changes only on the GAP entry edge, never while win_en=1.

## Timing
- Reset values:
  - s_ready=1 (follows from full=0)
  - bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0
  - rd_bank=0, win_en=0, frame_cnt=0, cfg_err=0
  - wr_bank=0, wr_addr=0, full=00, FSM=IDLE.
- Reset asserted mid-frame discards all partial and full frames. No BRAM write occurs while rst_n=0.
- Write latency: accept at edge T drives the BRAM port A signals during cycle T+1. bram_ena/bram_wea fall the cycle after the last accept if there is no new accept.
- Last pixel accepted at edge T: full set at edge T+1; FSM enters RUN (win_en=1) at edge T+2.
- win_done at edge D:
  - win_en=0 and rd_bank toggled at D+1.
  - Earliest next win_en=1 is D+3 (GAP, IDLE, RUN).
- Both banks full: s_ready=0 until the clear at the GAP entry edge. s_ready returns 1 combinationally in the cycle after that edge.
- frame_cnt wraps 0xFFFF -> 0x0000.

## Test plan
- Single frame: cfg 7x7, 49 pixels back-to-back with s_valid=1.
  - Required: addresses 0x000..0x030 written; s_ready stays 1; full=01; win_en rises 2 cycles after the last accept; rd_bank=0.
- Overlap: pixels for frame 2 stream during RUN of frame 1.
  - Required: frame 2 writes go to 0x400..0x430; after win_done, rd_bank=1 and win_en re-rises 3 cycles later; frame_cnt=1 after first done.
- Backpressure: three 4x4 frames streamed continuously, win_done held off.
  - Required: s_ready=0 after 32 accepts; no BRAM write until the first win_done; the 33rd accept lands at 0x000 one cycle after the GAP entry.
- Illegal cfg: 0x7 then 40x40.
  - Required: cfg_err=1 in both cases; frame completes after 1024 accepts; cfg_err stays 1 through later legal frames.
- Spurious done: win_done pulses in IDLE and GAP.
  - Required: no change to full, rd_bank or frame_cnt.
- Reset mid-frame after 20 of 49 pixels.
  - Required: all outputs return to reset values; the next frame writes from 0x000.
